// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-outstanding imem requests, 2-entry {instr, pc} buffer to decode.
// Response in cycle k is visible to decode in k+1; requests issue only when the buffer can take the reply.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        iClk,
    input  logic        iRst,
    output logic        oImemReq,
    output logic [31:0] oImemAddr,
    input  logic        iImemValid,
    input  logic [31:0] iImemData,
    output logic [31:0] oInstruction,
    output logic        oInstrValid,
    output logic [31:0] oPc,
    input  logic        iStall,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPc,
    input  logic        iHalt,
    output logic        oHalted
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        outstanding_q, outstanding_d;
    logic        discard_q, discard_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];
    logic [31:0] buf_pc_q [2];
    logic [31:0] buf_pc_d [2];

    logic        run;
    logic        consume;
    logic [1:0]  count_after_pop;
    logic        resp;
    logic        redirect;
    logic        halt;
    logic        flush;
    logic        push;
    logic        pop;

    always_comb begin
        // Reset dominates everything, including the combinational outputs.
        run             = (state_q == ST_RUN) && !iRst;
        oInstrValid     = run && (count_q != 2'd0);
        oInstruction    = oInstrValid ? buf_instr_q[head_q] : 32'h0;
        oPc             = oInstrValid ? buf_pc_q[head_q] : 32'h0;
        oHalted         = (state_q == ST_HALTED) && !iRst;
        consume         = oInstrValid && !iStall;
        count_after_pop = count_q - {1'b0, consume};
        oImemReq        = run && !iRedirect && !outstanding_q && (count_after_pop != 2'd2);
        oImemAddr       = fetch_pc_q;

        resp     = iImemValid && outstanding_q && !iRst;
        redirect = run && iRedirect;
        halt     = run && !iRedirect && iHalt && consume;
        flush    = redirect || halt || (state_q == ST_HALTED);
        push     = resp && !discard_q && run && !flush;
        pop      = consume && !flush;

        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        head_d        = head_q;
        tail_d        = tail_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;

        if (oImemReq) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + PC_STEP;
        end
        if (resp) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end
        // A reply still in flight belongs to the abandoned path.
        if (redirect) begin
            fetch_pc_d = iRedirectPc;
            if (outstanding_q && !iImemValid) begin
                discard_d = 1'b1;
            end
        end
        if (push) begin
            buf_instr_d[tail_q] = iImemData;
            buf_pc_d[tail_q]    = req_pc_q;
            tail_d              = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end
        if (halt) begin
            state_d = ST_HALTED;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    // Payload needs no reset: it is only visible while count is non-zero.
    always_ff @(posedge iClk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem with programmable latency, data = addr ^ A5A5_0000.
module tb_fetch_unit;

    logic        iClk;
    logic        iRst;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemValid;
    logic [31:0] iImemData;
    logic [31:0] oInstruction;
    logic        oInstrValid;
    logic [31:0] oPc;
    logic        iStall;
    logic        iRedirect;
    logic [31:0] iRedirectPc;
    logic        iHalt;
    logic        oHalted;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .oImemReq     (oImemReq),
        .oImemAddr    (oImemAddr),
        .iImemValid   (iImemValid),
        .iImemData    (iImemData),
        .oInstruction (oInstruction),
        .oInstrValid  (oInstrValid),
        .oPc          (oPc),
        .iStall       (iStall),
        .iRedirect    (iRedirect),
        .iRedirectPc  (iRedirectPc),
        .iHalt        (iHalt),
        .oHalted      (oHalted)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int          errors = 0;
    int          checks = 0;
    int          lat = 1;
    logic        mem_pend = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] req_q [$];
    logic [31:0] pc_q [$];
    logic [31:0] ins_q [$];
    int          n_req;
    int          n_pc;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // One clock: log requests and consumed instructions, then run the memory model.
    task automatic cycle();
        logic        got_req;
        logic [31:0] got_addr;
        #1;
        got_req  = oImemReq;
        got_addr = oImemAddr;
        if (oImemReq) req_q.push_back(oImemAddr);
        if (oInstrValid && !iStall) begin
            pc_q.push_back(oPc);
            ins_q.push_back(oInstruction);
        end
        @(posedge iClk);
        #1;
        iImemValid = 1'b0;
        iImemData  = 32'h0;
        if (got_req) begin
            mem_pend = 1'b1;
            mem_addr = got_addr;
            mem_wait = lat;
        end
        if (mem_pend) begin
            mem_wait--;
            if (mem_wait == 0) begin
                iImemValid = 1'b1;
                iImemData  = mem_addr ^ KEY;
                mem_pend   = 1'b0;
            end
        end
        @(negedge iClk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        iRst = 1'b1; iStall = 1'b0; iRedirect = 1'b0; iHalt = 1'b0; iRedirectPc = 32'h0;
        iImemValid = 1'b0; iImemData = 32'h0; mem_pend = 1'b0;
        cycle();
        cycle();
        iRst = 1'b0;
        req_q.delete(); pc_q.delete(); ins_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and sequential fetch, 1-cycle memory
        iRst = 1'b1; iStall = 1'b0; iRedirect = 1'b0; iHalt = 1'b0; iRedirectPc = 32'h0;
        iImemValid = 1'b0; iImemData = 32'h0;
        cycle();
        check("rst_req",    32'(oImemReq), 32'h0);
        check("rst_valid",  32'(oInstrValid), 32'h0);
        check("rst_instr",  oInstruction, 32'h0);
        check("rst_pc",     oPc, 32'h0);
        check("rst_halted", 32'(oHalted), 32'h0);
        lat = 1;
        do_reset();
        #1;
        check("first_req",  32'(oImemReq), 32'h1);
        check("first_addr", oImemAddr, 32'h0);
        check("first_valid", 32'(oInstrValid), 32'h0);
        run(14);
        for (int i = 0; i < 3; i++) check("seq_req", qget(req_q, i), 32'(i * 4));
        check("seq_count", 32'(pc_q.size()), 32'd6);
        for (int i = 0; i < pc_q.size(); i++) begin
            check("seq_pc",    qget(pc_q, i), 32'(i * 4));
            check("seq_instr", qget(ins_q, i), 32'(i * 4) ^ KEY);
        end

        // Stall with full buffer
        do_reset();
        iStall = 1'b1;
        run(10);
        #1;
        check("full_req",   32'(oImemReq), 32'h0);
        check("full_valid", 32'(oInstrValid), 32'h1);
        check("full_pc",    oPc, 32'h0);
        check("full_instr", oInstruction, KEY);
        check("full_nreq",  32'(req_q.size()), 32'd2);
        iStall = 1'b0;
        run(8);
        for (int i = 0; i < 3; i++) begin
            check("unstall_pc",    qget(pc_q, i), 32'(i * 4));
            check("unstall_instr", qget(ins_q, i), 32'(i * 4) ^ KEY);
        end

        // Redirect while the request to 0x8 is outstanding, 3-cycle memory
        lat = 3;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (qget(req_q, req_q.size() - 1) == 32'h8) break;
            cycle();
        end
        check("wait_req8", qget(req_q, req_q.size() - 1), 32'h8);
        iRedirect = 1'b1; iRedirectPc = 32'h100;
        #1;
        check("redir_noreq", 32'(oImemReq), 32'h0);
        cycle();
        iRedirect = 1'b0;
        n_req = req_q.size();
        n_pc  = pc_q.size();
        run(12);
        check("redir_prev_pc",  qget(pc_q, n_pc - 1), 32'h4);
        check("redir_req",      qget(req_q, n_req), 32'h100);
        check("redir_pc",       qget(pc_q, n_pc), 32'h100);
        check("redir_instr",    qget(ins_q, n_pc), 32'hA5A5_0100);

        // Halt at 0xC
        lat = 1;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (oInstrValid && oPc == 32'hC) break;
            cycle();
        end
        check("wait_pcC", oPc, 32'hC);
        iHalt = 1'b1;
        cycle();
        iHalt = 1'b0;
        check("halt_halted", 32'(oHalted), 32'h1);
        check("halt_valid",  32'(oInstrValid), 32'h0);
        check("halt_instr",  oInstruction, 32'h0);
        check("halt_pc",     oPc, 32'h0);
        n_req = req_q.size();
        run(20);
        check("halt_noreq",  32'(req_q.size()), 32'(n_req));
        check("halt_sticky", 32'(oHalted), 32'h1);
        do_reset();
        #1;
        check("restart_halted", 32'(oHalted), 32'h0);
        check("restart_req",    32'(oImemReq), 32'h1);
        check("restart_addr",   oImemAddr, 32'h0);

        // Redirect and halt in the same cycle
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (oInstrValid) break;
            cycle();
        end
        check("wait_valid", 32'(oInstrValid), 32'h1);
        iRedirect = 1'b1; iRedirectPc = 32'h40; iHalt = 1'b1;
        cycle();
        iRedirect = 1'b0; iHalt = 1'b0;
        check("rh_halted", 32'(oHalted), 32'h0);
        run(6);
        check("rh_halted2", 32'(oHalted), 32'h0);
        check("rh_req",     qget(req_q, 1), 32'h40);
        check("rh_pc",      qget(pc_q, 1), 32'h40);
        check("rh_instr",   qget(ins_q, 1), 32'hA5A5_0040);

        // Address wrap
        do_reset();
        iRedirect = 1'b1; iRedirectPc = 32'hFFFF_FFFC;
        #1;
        check("wrap_noreq", 32'(oImemReq), 32'h0);
        cycle();
        iRedirect = 1'b0;
        run(6);
        check("wrap_req0",  qget(req_q, 0), 32'hFFFF_FFFC);
        check("wrap_req1",  qget(req_q, 1), 32'h0);
        check("wrap_pc0",   qget(pc_q, 0), 32'hFFFF_FFFC);
        check("wrap_ins0",  qget(ins_q, 0), 32'h5A5A_FFFC);
        check("wrap_pc1",   qget(pc_q, 1), 32'h0);

        // Reset while the request to 0x4 is outstanding, 3-cycle memory
        lat = 3;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (qget(req_q, req_q.size() - 1) == 32'h4) break;
            cycle();
        end
        check("wait_req4", qget(req_q, req_q.size() - 1), 32'h4);
        iRst = 1'b1;
        #1;
        check("midrst_req", 32'(oImemReq), 32'h0);
        cycle();
        cycle();
        iRst = 1'b0;
        req_q.delete(); pc_q.delete(); ins_q.delete();
        #1;
        check("midrst_addr", oImemAddr, 32'h0);
        run(10);
        check("midrst_n",    32'(pc_q.size()), 32'd2);
        check("midrst_pc0",  qget(pc_q, 0), 32'h0);
        check("midrst_ins0", qget(ins_q, 0), KEY);
        check("midrst_pc1",  qget(pc_q, 1), 32'h4);
        check("midrst_ins1", qget(ins_q, 1), 32'hA5A5_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
